sfm_addmul_sched: RTL and testbench

Scheduler for the shared vector add/multiply FMA datapath (`sfm_fp_vect_addmul`). It decides each cycle whether the datapath serves the ADD stream or the MUL stream, and drives the datapath's `operation_i` select. Arbitration is work-conserving round-robin with a bounded burst length. An in-flight credit counter keeps the number of vectors inside the FMA pipeline within a configured limit and reports when the pipeline has drained.

---
 rtl/sfm_addmul_sched.sv | 139 +++++++++++++
 tb/tb_sfm_addmul_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfm_addmul_sched.sv
// sfm_addmul_sched
// Chooses, cycle by cycle, whether the shared FMA datapath serves the ADD or
// the MUL vector stream. Round-robin with a bounded burst, gated by an
// in-flight credit counter that also signals when the pipeline has drained.

package sfm_pkg;
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } operation_t;
endpackage

// State table (cur_op_q)
//   state  | meaning
//   OP_ADD | ADD stream owns the datapath; burst_cnt_q counts its accepts
//   OP_MUL | MUL stream owns the datapath; burst_cnt_q counts its accepts
module sfm_addmul_sched #(
  parameter int MAX_BURST       = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                add_req_i,
  input  logic                mul_req_i,
  output logic                add_gnt_o,
  output logic                mul_gnt_o,
  input  logic                add_accept_i,
  input  logic                mul_accept_i,
  input  logic                add_retire_i,
  input  logic                mul_retire_i,
  output sfm_pkg::operation_t operation_o,
  output logic [CNT_W-1:0]    outstanding_o,
  output logic                busy_o,
  output logic                err_o
);
  import sfm_pkg::*;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]    BURST_MAX = BW'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

  operation_t        cur_op_q, cur_op_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              err_q, err_d;

  operation_t        oth_op;
  operation_t        sel;
  logic              cur_req;
  logic              oth_req;
  logic              exhausted;
  logic              full;
  logic              empty;
  logic              advance;
  logic              accept_sel;
  logic              any_accept;
  logic              any_retire;

  // Arbitration terms derived from the current owner and both requests
  always_comb begin
    oth_op     = (cur_op_q == OP_ADD) ? OP_MUL : OP_ADD;
    cur_req    = (cur_op_q == OP_ADD) ? add_req_i : mul_req_i;
    oth_req    = (cur_op_q == OP_ADD) ? mul_req_i : add_req_i;
    exhausted  = (burst_cnt_q == BURST_MAX);
    full       = (outstanding_q == CNT_MAX);
    empty      = (outstanding_q == '0);
    // Yield only when the other side is waiting, so a lone requester keeps the datapath
    sel        = (oth_req && (!cur_req || exhausted)) ? oth_op : cur_op_q;
    accept_sel = (sel == OP_ADD) ? add_accept_i : mul_accept_i;
    advance    = enable_i && !full;
    any_accept = add_accept_i | mul_accept_i;
    any_retire = add_retire_i | mul_retire_i;
  end

  // Owner and burst registers; clear shares the reset path and wins over everything
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cur_op_q    <= OP_ADD;
      burst_cnt_q <= '0;
    end else begin
      cur_op_q    <= cur_op_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next owner: hand over on a switch, otherwise count accepts up to saturation
  always_comb begin
    cur_op_d    = cur_op_q;
    burst_cnt_d = burst_cnt_q;
    if (advance) begin
      if (sel != cur_op_q) begin
        cur_op_d    = sel;
        burst_cnt_d = BW'(accept_sel);
      end else if (accept_sel && !exhausted) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end
    end
  end

  // Grants and op select follow the arbitration result in the same cycle
  always_comb begin
    operation_o = sel;
    add_gnt_o   = advance && add_req_i && (sel == OP_ADD);
    mul_gnt_o   = advance && mul_req_i && (sel == OP_MUL);
  end

  // Credit counter and sticky protocol error
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // Accept-only and retire-only moves are refused at the rails; both together net out
  always_comb begin
    outstanding_d = outstanding_q;
    if (any_accept && !any_retire) begin
      if (!full) outstanding_d = outstanding_q + CNT_W'(1);
    end else if (any_retire && !any_accept) begin
      if (!empty) outstanding_d = outstanding_q - CNT_W'(1);
    end
    err_d = err_q
          | (any_retire && empty)
          | (any_accept && full)
          | (add_accept_i && mul_accept_i);
  end

  assign outstanding_o = outstanding_q;
  assign busy_o        = !empty;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sfm_addmul_sched.sv
// Scoreboard bench for sfm_addmul_sched: a stimulus process drives requests
// and datapath handshakes from a behavioural model and queues the expected
// outputs; a monitor compares them on the falling edge.

module tb_sfm_addmul_sched;
  localparam int MB    = 4;
  localparam int MO    = 4;
  localparam int CNT_W = $clog2(MO + 1);

  logic clk_i = 1'b0;
  logic rst_i, clear_i, enable_i;
  logic add_req_i, mul_req_i, add_gnt_o, mul_gnt_o;
  logic add_accept_i, mul_accept_i, add_retire_i, mul_retire_i;
  sfm_pkg::operation_t operation_o;
  logic [CNT_W-1:0] outstanding_o;
  logic busy_o, err_o;

  sfm_addmul_sched #(.MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .add_req_i(add_req_i), .mul_req_i(mul_req_i),
    .add_gnt_o(add_gnt_o), .mul_gnt_o(mul_gnt_o),
    .add_accept_i(add_accept_i), .mul_accept_i(mul_accept_i),
    .add_retire_i(add_retire_i), .mul_retire_i(mul_retire_i),
    .operation_o(operation_o), .outstanding_o(outstanding_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             ga;
    logic             gm;
    logic             op;
    logic [CNT_W-1:0] out;
    logic             busy;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner (0=ADD,1=MUL), length of its current run,
  // in-flight vectors in issue order, sticky error.
  int m_owner;
  int m_run;
  int m_err;
  int inflight[$];

  function automatic void model_reset();
    m_owner = 0;
    m_run   = 0;
    m_err   = 0;
    inflight.delete();
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b0;
    add_req_i = 1'b0; mul_req_i = 1'b0;
    add_accept_i = 1'b0; mul_accept_i = 1'b0;
    add_retire_i = 1'b0; mul_retire_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus. ret retires the oldest in-flight vector if any;
  // bad_ret forces an ADD retire regardless of what is in flight.
  task automatic step(input bit ar, input bit mr, input bit en,
                      input bit ardy, input bit mrdy,
                      input bit ret, input bit bad_ret, input bit clr);
    int   cur_wants, oth_wants, winner, cnt, nxt;
    bit   ga, gm, aa, am, ra, rm, is_full;
    exp_t e;
    cnt       = inflight.size();
    cur_wants = (m_owner == 0) ? int'(ar) : int'(mr);
    oth_wants = (m_owner == 0) ? int'(mr) : int'(ar);
    if (oth_wants != 0 && (cur_wants == 0 || m_run >= MB)) winner = 1 - m_owner;
    else winner = m_owner;
    is_full = (cnt >= MO);
    ga = en && !is_full && ar && (winner == 0);
    gm = en && !is_full && mr && (winner == 1);
    aa = ga && ardy;
    am = gm && mrdy;
    ra = 1'b0; rm = 1'b0;
    if (ret && cnt > 0) begin
      if (inflight[0] == 0) ra = 1'b1; else rm = 1'b1;
    end
    if (bad_ret) ra = 1'b1;

    add_req_i = ar; mul_req_i = mr; enable_i = en; clear_i = clr;
    add_accept_i = aa; mul_accept_i = am;
    add_retire_i = ra; mul_retire_i = rm;

    e.ga = ga; e.gm = gm; e.op = winner[0];
    e.out = CNT_W'(cnt); e.busy = (cnt != 0); e.err = (m_err != 0);
    exp_q.push_back(e);

    @(posedge clk_i);
    if (clr) begin
      model_reset();
    end else begin
      if ((ra || rm) && cnt == 0) m_err = 1;
      if ((aa || am) && is_full) m_err = 1;
      nxt = cnt + int'(aa || am) - int'(ra || rm);
      if (nxt >= 0 && nxt <= MO) begin
        if ((ra || rm) && cnt > 0) void'(inflight.pop_front());
        if (aa || am) inflight.push_back(aa ? 0 : 1);
      end
      if (en && !is_full) begin
        if (winner != m_owner) begin
          m_owner = winner;
          m_run   = int'(aa || am);
        end else if (aa || am) begin
          m_run = (m_run + 1 > MB) ? MB : m_run + 1;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (inflight.size() > 0 && guard < 20) begin
      step(0, 0, 1, 1, 1, 1, 0, 0);
      guard++;
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (add_gnt_o !== e.ga || mul_gnt_o !== e.gm || operation_o !== e.op ||
            outstanding_o !== e.out || busy_o !== e.busy || err_o !== e.err) begin
          n_bad++;
          $display("FAIL cycle%0d outputs: got ga=%b gm=%b op=%b out=%0d busy=%b err=%b, want ga=%b gm=%b op=%b out=%0d busy=%b err=%b",
                   n_cmp, add_gnt_o, mul_gnt_o, operation_o, outstanding_o, busy_o, err_o,
                   e.ga, e.gm, e.op, e.out, e.busy, e.err);
        end
      end
    end
  end

  initial begin
    int guard;
    do_reset();

    // Idle after reset
    step(0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 0);

    // Lone ADD requester, always ready, one retire per cycle
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 1, 1, 0, 0);
    drain();

    // Both requesting: bursts of MB alternate
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 1, 1, 0, 0);
    drain();

    // MUL granted but stalled, ADD arrives one cycle later
    do_reset();
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 0);
    drain();

    // Fill to the limit, then release one credit
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 0);
    drain();

    // Clear with vectors in flight, then an illegal retire makes err stick
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1, 0, 0);
    drain();
    do_reset();
    step(0, 0, 1, 1, 1, 0, 0, 0);

    // Disabled: no grants, owner frozen, retires still drain
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0, 0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, 1'b0,
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 1, 1, 1, 0, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
